pwm_tone_ctrl: RTL

//  Memory-mapped PWM/tone peripheral that consumes the store-side strobes from the

---
 rtl/pwm_tone_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/pwm_tone_ctrl.sv
// Memory-mapped PWM/tone peripheral: double-buffered duty and tone half-period registers,
// free-running PWM carrier gated by a tone square wave, registered output pin.
module pwm_tone_ctrl #(
   parameter int unsigned PWM_BITS  = 10,
   parameter int unsigned TONE_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pwm_we,
   input  logic                 pwm_tone_we,
   input  logic [31:0]          wdata,
   output logic                 pwm_out,
   output logic [PWM_BITS-1:0]  duty_q,
   output logic [TONE_BITS-1:0] tone_q
);

   localparam logic [PWM_BITS-1:0]  PwmMax  = '1;
   localparam logic [PWM_BITS-1:0]  PwmOne  = PWM_BITS'(1);
   localparam logic [TONE_BITS-1:0] ToneOne = TONE_BITS'(1);

   logic [PWM_BITS-1:0]  duty_d, duty_act_q, duty_act_d, pwm_cnt_q, pwm_cnt_d;
   logic [TONE_BITS-1:0] tone_d, tone_act_q, tone_act_d, tone_cnt_q, tone_cnt_d;
   logic                 tone_sq_q, tone_sq_d, pwm_out_d;
   logic                 pwm_raw, gate, tone_on, tone_wrap;

   // Only the low lanes of the store data are architecturally meaningful.
   logic wdata_unused;
   assign wdata_unused = ^wdata;

   assign tone_on   = (tone_act_q != '0);
   assign tone_wrap = (tone_cnt_q == tone_act_q - ToneOne);
   assign pwm_raw   = (pwm_cnt_q < duty_act_q);
   assign gate      = tone_on ? tone_sq_q : 1'b1;

   always_comb begin
      duty_d = duty_q;
      tone_d = tone_q;
      if (pwm_we && !pwm_tone_we) begin
         duty_d = wdata[PWM_BITS-1:0];
      end
      if (pwm_we && pwm_tone_we) begin
         tone_d = wdata[TONE_BITS-1:0];
      end
   end

   // Active registers sample the pre-write shadow, so a write at a boundary waits one period.
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q + PwmOne;
      duty_act_d = (pwm_cnt_q == PwmMax) ? duty_q : duty_act_q;
      tone_cnt_d = tone_cnt_q;
      tone_sq_d  = tone_sq_q;
      tone_act_d = tone_act_q;
      if (!tone_on) begin
         tone_cnt_d = '0;
         tone_act_d = tone_q;
      end else if (tone_wrap) begin
         tone_cnt_d = '0;
         tone_sq_d  = ~tone_sq_q;
         tone_act_d = tone_q;
      end else begin
         tone_cnt_d = tone_cnt_q + ToneOne;
      end
      pwm_out_d = pwm_raw & gate;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q     <= '0;
         tone_q     <= '0;
         duty_act_q <= '0;
         tone_act_q <= '0;
         pwm_cnt_q  <= '0;
         tone_cnt_q <= '0;
         tone_sq_q  <= 1'b0;
         pwm_out    <= 1'b0;
      end else begin
         duty_q     <= duty_d;
         tone_q     <= tone_d;
         duty_act_q <= duty_act_d;
         tone_act_q <= tone_act_d;
         pwm_cnt_q  <= pwm_cnt_d;
         tone_cnt_q <= tone_cnt_d;
         tone_sq_q  <= tone_sq_d;
         pwm_out    <= pwm_out_d;
      end
   end

endmodule
